// File: rtl/riscv_enc_pkg.sv
// Shared types and immediate range limits for the RV32I instruction encoder.
// Imported by the packer and the loader FSM.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CARGA = 2'd1,
    ST_DRENA = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMM_U_MIN  = -32'sd524288;
  localparam logic signed [31:0] IMM_U_MAX  = 32'sd524287;
  localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX  = 32'sd1048574;

  function automatic logic in_range(
    input logic        [31:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I word packer with immediate range check.
// Illegal formats and out-of-range immediates raise o_reject.
module inst_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_reject
);

  always_comb begin
    o_word   = '0;
    o_reject = 1'b1;
    unique case (1'b1)
      (i_fmt == FMT_R): begin
        o_word   = {i_funct7, i_rs2, i_rs1,
                    i_funct3, i_rd, i_opcode};
        o_reject = 1'b0;
      end
      (i_fmt == FMT_I): begin
        o_word   = {i_imm[11:0], i_rs1,
                    i_funct3, i_rd, i_opcode};
        o_reject = !in_range(i_imm, IMM_IS_MIN,
                             IMM_IS_MAX);
      end
      (i_fmt == FMT_S): begin
        o_word   = {i_imm[11:5], i_rs2, i_rs1,
                    i_funct3, i_imm[4:0], i_opcode};
        o_reject = !in_range(i_imm, IMM_IS_MIN,
                             IMM_IS_MAX);
      end
      (i_fmt == FMT_B): begin
        o_word   = {i_imm[12], i_imm[10:5], i_rs2,
                    i_rs1, i_funct3, i_imm[4:1],
                    i_imm[11], i_opcode};
        o_reject = !in_range(i_imm, IMM_B_MIN,
                             IMM_B_MAX) || i_imm[0];
      end
      (i_fmt == FMT_U): begin
        o_word   = {i_imm[19:0], i_rd, i_opcode};
        o_reject = !in_range(i_imm, IMM_U_MIN,
                             IMM_U_MAX);
      end
      (i_fmt == FMT_J): begin
        o_word   = {i_imm[20], i_imm[10:1], i_imm[11],
                    i_imm[19:12], i_rd, i_opcode};
        o_reject = !in_range(i_imm, IMM_J_MIN,
                             IMM_J_MAX) || i_imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: accepts decoded fields, packs them and writes
// consecutive instruction-memory words starting at BASE.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_formato,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_inmediato,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_idx
);

  state_e              r_state;
  logic [ADDR_W:0]     r_left;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_err_idx;

  logic [31:0]         w_word;
  logic                w_reject;
  logic                w_accept;

  inst_pack u_pack (
    .i_fmt    (i_formato),
    .i_opcode (i_opcode),
    .i_funct3 (i_funct3),
    .i_funct7 (i_funct7),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_imm    (i_inmediato),
    .o_word   (w_word),
    .o_reject (w_reject)
  );

  assign w_accept = i_valid && (r_state == ST_CARGA);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_left    <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_error <= 1'b0;
            r_idx   <= '0;
            r_left  <= i_num_words;
            if (i_num_words == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_CARGA;
            end
          end
        end
        ST_CARGA: begin
          if (w_accept) begin
            // rejected words still consume their address slot
            r_we    <= !w_reject;
            r_addr  <= BASE + r_idx;
            r_wdata <= w_word;
            r_idx   <= r_idx + ADDR_W'(1);
            r_left  <= r_left - (ADDR_W+1)'(1);
            if (w_reject && !r_error) begin
              r_error   <= 1'b1;
              r_err_idx <= r_idx;
            end
            if (r_left == (ADDR_W+1)'(1))
              r_state <= ST_DRENA;
          end
        end
        ST_DRENA: begin
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_FIN: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = (r_state == ST_CARGA);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_err_idx   = r_err_idx;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: hand-coded vectors plus random loads checked
// against an arithmetic encoding model; a second DUT covers address wrap.
module tb_inst_encoder;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW:0]   num;
  logic          valid;
  logic [2:0]    fmt;
  logic [6:0]    op, f7;
  logic [2:0]    f3;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;

  logic          rdy[2], we[2], busy[2], done[2], err[2];
  logic [AW-1:0] addr[2], eidx[2];
  logic [31:0]   wd[2];

  int checks = 0;
  int errors = 0;
  bit exp_err;
  int exp_eidx;
  int bases[2] = '{0, DEPTH - 1};

  inst_encoder #(.ADDR_W(AW), .BASE(10'd0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_num_words(num), .i_valid(valid), .o_ready(rdy[0]),
    .i_formato(fmt), .i_opcode(op), .i_funct3(f3),
    .i_funct7(f7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_inmediato(imm), .o_mem_we(we[0]),
    .o_mem_addr(addr[0]), .o_mem_wdata(wd[0]),
    .o_busy(busy[0]), .o_done(done[0]),
    .o_error(err[0]), .o_err_idx(eidx[0])
  );

  inst_encoder #(.ADDR_W(AW), .BASE(10'h3FF)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_num_words(num), .i_valid(valid), .o_ready(rdy[1]),
    .i_formato(fmt), .i_opcode(op), .i_funct3(f3),
    .i_funct7(f7), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_inmediato(imm), .o_mem_we(we[1]),
    .o_mem_addr(addr[1]), .o_mem_wdata(wd[1]),
    .o_busy(busy[1]), .o_done(done[1]),
    .o_error(err[1]), .o_err_idx(eidx[1])
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: spec rules as plain integer arithmetic
  function automatic bit ref_ok(input logic [2:0] f,
                                input int s);
    case (f)
      3'd0: return 1'b1;
      3'd1, 3'd2: return s >= -2048 && s <= 2047;
      3'd3: return s >= -4096 && s <= 4094 && s % 2 == 0;
      3'd4: return s >= -524288 && s <= 524287;
      3'd5: return s >= -1048576 && s <= 1048574
                   && s % 2 == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] v,
                                      input int hi,
                                      input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_word(input vec_t v);
    logic [31:0] i, o, d, r1, r2, f;
    i  = v.imm;
    o  = 32'(v.op);
    d  = 32'(v.rd) << 7;
    f  = 32'(v.f3) << 12;
    r1 = 32'(v.rs1) << 15;
    r2 = 32'(v.rs2) << 20;
    case (v.fmt)
      3'd0: return (32'(v.f7) << 25) | r2 | r1 | f | d | o;
      3'd1: return (fld(i, 11, 0) << 20) | r1 | f | d | o;
      3'd2: return (fld(i, 11, 5) << 25) | r2 | r1 | f
                   | (fld(i, 4, 0) << 7) | o;
      3'd3: return (fld(i, 12, 12) << 31)
                   | (fld(i, 10, 5) << 25) | r2 | r1 | f
                   | (fld(i, 4, 1) << 8)
                   | (fld(i, 11, 11) << 7) | o;
      3'd4: return (fld(i, 19, 0) << 12) | d | o;
      3'd5: return (fld(i, 20, 20) << 31)
                   | (fld(i, 10, 1) << 21)
                   | (fld(i, 11, 11) << 20)
                   | (fld(i, 19, 12) << 12) | d | o;
      default: return 32'd0;
    endcase
  endfunction

  function automatic vec_t mk(input int f, input int o,
                              input int c3, input int c7,
                              input int d, input int s1,
                              input int s2, input int im,
                              input bit ok,
                              input logic [31:0] w);
    vec_t v;
    v.fmt = 3'(f);   v.op = 7'(o);
    v.f3 = 3'(c3);   v.f7 = 7'(c7);
    v.rd = 5'(d);    v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.imm = 32'(im); v.ok = ok;      v.word = w;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int lo, hi, s;
    if ($urandom_range(9) == 0)
      v.fmt = 3'($urandom_range(7, 6));
    else
      v.fmt = 3'($urandom_range(5, 0));
    v.op = 7'($urandom); v.f3 = 3'($urandom);
    v.f7 = 7'($urandom); v.rd = 5'($urandom);
    v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
    case (v.fmt)
      3'd1, 3'd2: begin lo = -2048; hi = 2047; end
      3'd3: begin lo = -4096; hi = 4094; end
      3'd4: begin lo = -524288; hi = 524287; end
      default: begin lo = -1048576; hi = 1048574; end
    endcase
    case ($urandom_range(5))
      0: s = lo - 1;
      1: s = lo;
      2: s = hi;
      3: s = hi + 1 + int'($urandom_range(1));
      4: s = int'($urandom);
      default: s = int'($urandom_range(0, 3 * (hi - lo)))
                   + lo - (hi - lo);
    endcase
    v.imm  = 32'(s);
    v.ok   = ref_ok(v.fmt, s);
    v.word = ref_word(v);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    fmt = v.fmt; op = v.op; f3 = v.f3; f7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  task automatic chk_status(input string tag, input bit r,
                            input bit b, input bit d);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s ready%0d", tag, i), 32'(rdy[i]), 32'(r));
      chk($sformatf("%s busy%0d", tag, i), 32'(busy[i]), 32'(b));
      chk($sformatf("%s done%0d", tag, i), 32'(done[i]), 32'(d));
      chk($sformatf("%s error%0d", tag, i), 32'(err[i]),
          32'(exp_err));
      if (exp_err)
        chk($sformatf("%s err_idx%0d", tag, i), 32'(eidx[i]),
            32'(exp_eidx));
    end
  endtask

  task automatic chk_write(input string tag, input bit ew,
                           input int ei, input logic [31:0] ed);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s we%0d", tag, i), 32'(we[i]), 32'(ew));
      if (ew) begin
        chk($sformatf("%s addr%0d", tag, i), 32'(addr[i]),
            32'((bases[i] + ei) % DEPTH));
        chk($sformatf("%s wdata%0d", tag, i), wd[i], ed);
      end
    end
  endtask

  // one full load; gap = % chance of idling IN_VALID per cycle
  task automatic run_load(input string tag, input vec_t q[$],
                          input int gap, input bit poke);
    int n, idx, budget, ei;
    bit ew;
    logic [31:0] ed;
    n = q.size(); idx = 0; budget = 0;
    ew = 1'b0; ei = 0; ed = '0;
    @(negedge clk);
    start = 1'b1; num = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    exp_err = 1'b0;
    if (n == 0) begin
      chk_status({tag, " fin"}, 1'b0, 1'b1, 1'b1);
      chk_write({tag, " fin"}, 1'b0, 0, '0);
      @(negedge clk);
      chk_status({tag, " idle"}, 1'b0, 1'b0, 1'b0);
      chk_write({tag, " idle"}, 1'b0, 0, '0);
      return;
    end
    while (idx < n && budget < 2000) begin
      chk_status({tag, " carga"}, 1'b1, 1'b1, 1'b0);
      chk_write({tag, " carga"}, ew, ei, ed);
      start = poke && (idx == 1);
      num = poke ? '0 : (AW+1)'(n);
      if (int'($urandom_range(99)) >= gap) begin
        apply(q[idx]);
        valid = 1'b1;
        ew = q[idx].ok; ei = idx; ed = q[idx].word;
        if (!q[idx].ok && !exp_err) begin
          exp_err = 1'b1; exp_eidx = idx;
        end
        idx++;
      end else begin
        valid = 1'b0;
        ew = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    if (idx < n) begin
      errors++;
      $display("FAIL %s timeout: accepted %0d want %0d",
               tag, idx, n);
    end
    valid = 1'b0; start = 1'b0;
    chk_status({tag, " drena"}, 1'b0, 1'b1, 1'b0);
    chk_write({tag, " drena"}, ew, ei, ed);
    @(negedge clk);
    chk_status({tag, " fin"}, 1'b0, 1'b1, 1'b1);
    chk_write({tag, " fin"}, 1'b0, 0, '0);
    @(negedge clk);
    chk_status({tag, " idle"}, 1'b0, 1'b0, 1'b0);
    chk_write({tag, " idle"}, 1'b0, 0, '0);
  endtask

  vec_t tab[$];
  vec_t q[$];

  initial begin
    rst = 1'b1; start = 1'b0; num = '0; valid = 1'b0;
    fmt = '0; op = '0; f3 = '0; f7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    exp_err = 1'b0; exp_eidx = 0;

    tab.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 5, 1, 32'h00500093));
    tab.push_back(mk(2, 'h23, 2, 0, 0, 3, 2, -4, 1, 32'hFE21AE23));
    tab.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, -8, 1, 32'hFE000CE3));
    tab.push_back(mk(5, 'h6F, 0, 0, 1, 0, 0, 2048, 1, 32'h001000EF));
    tab.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 4096, 0, 32'h0));
    tab.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 3, 0, 32'h0));
    tab.push_back(mk(4, 'h37, 0, 0, 5, 0, 0, 'h12345, 1,
                     32'h123452B7));
    tab.push_back(mk(0, 'h33, 0, 0, 3, 1, 2, 'hDEAD, 1,
                     32'h002081B3));
    tab.push_back(mk(4, 'h37, 0, 0, 1, 0, 0, -1, 1, 32'hFFFFF0B7));
    tab.push_back(mk(4, 'h37, 0, 0, 1, 0, 0, 'hFFFFF, 0, 32'h0));
    tab.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, -2048, 1,
                     32'h80000093));
    tab.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 2047, 1,
                     32'h7FF00093));
    tab.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 2048, 0, 32'h0));
    tab.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 4094, 1,
                     32'h7E000FE3));
    tab.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 4096, 0, 32'h0));
    tab.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, -1048576, 1,
                     32'h8000006F));
    tab.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1048576, 0, 32'h0));
    tab.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 5, 0, 32'h0));
    tab.push_back(mk(6, 'h13, 0, 0, 1, 0, 0, 0, 0, 32'h0));

    #12;
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk_write("reset", 1'b0, 0, '0);
    chk("reset addr0", 32'(addr[0]), 32'd0);
    chk("reset wdata0", wd[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    q = '{tab[0]};
    run_load("addi", q, 0, 1'b0);

    q = '{tab[1], tab[2], tab[3]};
    run_load("b2b", q, 0, 1'b0);

    q = '{tab[0], tab[4], tab[10], tab[5]};
    run_load("reject", q, 0, 1'b1);

    q.delete();
    run_load("zero", q, 0, 1'b0);

    run_load("table", tab, 0, 1'b0);

    q = '{tab[7], tab[6]};
    run_load("wrap", q, 20, 1'b0);

    // asynchronous reset in the middle of a 4-word load
    @(negedge clk);
    start = 1'b1; num = (AW+1)'(4);
    @(negedge clk);
    start = 1'b0;
    apply(tab[0]); valid = 1'b1;
    @(negedge clk);
    apply(tab[6]);
    @(negedge clk);
    chk("midrst pre we0", 32'(we[0]), 32'd1);
    chk("midrst pre addr0", 32'(addr[0]), 32'd1);
    apply(tab[7]);
    #2 rst = 1'b1;
    #1;
    exp_err = 1'b0;
    chk_status("midrst", 1'b0, 1'b0, 1'b0);
    chk_write("midrst", 1'b0, 0, '0);
    chk("midrst addr0", 32'(addr[0]), 32'd0);
    chk("midrst wdata0", wd[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_status("postrst", 1'b0, 1'b0, 1'b0);
      chk_write("postrst", 1'b0, 0, '0);
    end
    valid = 1'b0;
    q = '{tab[3]};
    run_load("reload", q, 0, 1'b0);

    for (int l = 0; l < 25; l++) begin
      q.delete();
      for (int k = 0; k < int'($urandom_range(12, 1)); k++)
        q.push_back(rand_vec());
      run_load($sformatf("rnd%0d", l), q, 30,
               1'($urandom_range(1)));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
